// File: rtl/udp_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding one UDP header + payload stream into the stack.
// A grant covers one header and the full payload frame through tlast; data paths are pure muxes.
module udp_tx_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int HDR_WIDTH  = 112,
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS-1:0]             s_hdr_valid,
    output logic [PORTS-1:0]             s_hdr_ready,
    input  logic [PORTS*HDR_WIDTH-1:0]   s_hdr_data,
    input  logic [PORTS*DATA_WIDTH-1:0]  s_payload_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]  s_payload_axis_tkeep,
    input  logic [PORTS-1:0]             s_payload_axis_tvalid,
    output logic [PORTS-1:0]             s_payload_axis_tready,
    input  logic [PORTS-1:0]             s_payload_axis_tlast,
    input  logic [PORTS-1:0]             s_payload_axis_tuser,
    output logic                         m_hdr_valid,
    input  logic                         m_hdr_ready,
    output logic [HDR_WIDTH-1:0]         m_hdr_data,
    output logic [DATA_WIDTH-1:0]        m_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_payload_axis_tkeep,
    output logic                         m_payload_axis_tvalid,
    input  logic                         m_payload_axis_tready,
    output logic                         m_payload_axis_tlast,
    output logic                         m_payload_axis_tuser,
    output logic [IW-1:0]                grant_index,
    output logic                         busy,
    output logic [31:0]                  frame_count,
    output logic [1:0]                   state_dbg
);

    // Handshake rule for every stream here: a transfer happens on a cycle where valid and
    // ready are both high at the rising clock edge; ready is routed only to the granted port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [31:0]   frame_count_q, frame_count_d;
    logic          busy_q, busy_d;

    logic          found;
    int            cand;
    logic [IW-1:0] cand_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= IW'(PORTS - 1);
            frame_count_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        last_grant_d          = last_grant_q;
        frame_count_d         = frame_count_q;
        found                 = 1'b0;
        cand                  = 0;
        cand_idx              = '0;
        s_hdr_ready           = '0;
        s_payload_axis_tready = '0;
        m_hdr_valid           = 1'b0;
        m_hdr_data            = '0;
        m_payload_axis_tdata  = '0;
        m_payload_axis_tkeep  = '0;
        m_payload_axis_tvalid = 1'b0;
        m_payload_axis_tlast  = 1'b0;
        m_payload_axis_tuser  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Scan starts one past the previous winner so every port gets a turn.
                for (int i = 1; i <= PORTS; i++) begin
                    cand = int'(last_grant_q) + i;
                    if (cand >= PORTS) cand = cand - PORTS;
                    cand_idx = IW'(cand);
                    if (!found && s_hdr_valid[cand_idx]) begin
                        found   = 1'b1;
                        grant_d = cand_idx;
                    end
                end
                if (found) state_d = ST_HDR;
            end
            ST_HDR: begin
                m_hdr_valid          = s_hdr_valid[grant_q];
                m_hdr_data           = s_hdr_data[grant_q*HDR_WIDTH +: HDR_WIDTH];
                s_hdr_ready[grant_q] = m_hdr_ready;
                if (m_hdr_valid && m_hdr_ready) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m_payload_axis_tdata  = s_payload_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                m_payload_axis_tkeep  = s_payload_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
                m_payload_axis_tvalid = s_payload_axis_tvalid[grant_q];
                m_payload_axis_tlast  = s_payload_axis_tlast[grant_q];
                m_payload_axis_tuser  = s_payload_axis_tuser[grant_q];
                s_payload_axis_tready[grant_q] = m_payload_axis_tready;
                if (m_payload_axis_tvalid && m_payload_axis_tready && m_payload_axis_tlast) begin
                    state_d       = ST_IDLE;
                    last_grant_d  = grant_q;
                    frame_count_d = frame_count_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign grant_index = grant_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;

endmodule
